// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter
// Tracks lot occupancy from one-cycle enter/exit pulses produced by the entry/exit
// detector. Provides empty/full status, sticky overflow/underflow errors and a
// count-changed strobe. Every output comes straight from a register.
// Optional build macro: OCC_BCD_EN adds a sequential double-dabble converter that
// presents the count as two BCD digits for the display stage. Without it the BCD
// outputs are tied low, so the port list is the same in both builds.
module parking_occupancy_counter #(
    parameter int MAX_CAP = 99,
    parameter int W       = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enter,
    input  logic         exit,
    input  logic         err_clr,
    output logic [W-1:0] count,
    output logic         empty,
    output logic         full,
    output logic         count_chg,
    output logic         overflow_err,
    output logic         underflow_err,
    output logic [3:0]   bcd_tens,
    output logic [3:0]   bcd_ones,
    output logic         bcd_valid
);

    // State encoding chosen so bit 0 is the empty flag and bit 1 the full flag,
    // which lets the state register drive both outputs with no decode logic.
    typedef enum logic [1:0] {
        S_PARTIAL = 2'b00,
        S_EMPTY   = 2'b01,
        S_FULL    = 2'b10
    } state_t;

    localparam logic [W-1:0] CAP = W'(MAX_CAP);
    localparam logic [W-1:0] ONE = W'(1);

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_count_next;
    logic           r_count_chg;
    logic           w_chg_next;
    logic           r_overflow_err;
    logic           r_underflow_err;
    logic           w_ovf_set;
    logic           w_unf_set;

    // Next-state decode: simultaneous enter and exit cancel out; saturate at both ends
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_chg_next   = 1'b0;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        case ({enter, exit})
            2'b10: begin
                if (r_state == S_FULL) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_count_next = r_count + ONE;
                    w_chg_next   = 1'b1;
                    w_state_next = (w_count_next == CAP) ? S_FULL : S_PARTIAL;
                end
            end
            2'b01: begin
                if (r_state == S_EMPTY) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_count_next = r_count - ONE;
                    w_chg_next   = 1'b1;
                    w_state_next = (w_count_next == '0) ? S_EMPTY : S_PARTIAL;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // State, count and flag registers; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_EMPTY;
            r_count         <= '0;
            r_count_chg     <= 1'b0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_count         <= w_count_next;
            r_count_chg     <= w_chg_next;
            r_overflow_err  <= w_ovf_set | (r_overflow_err & ~err_clr);
            r_underflow_err <= w_unf_set | (r_underflow_err & ~err_clr);
        end
    end

    assign count         = r_count;
    assign empty         = r_state[0];
    assign full          = r_state[1];
    assign count_chg     = r_count_chg;
    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;

`ifdef OCC_BCD_EN
    localparam int                STEP_W = $clog2(W + 1);
    localparam logic [STEP_W-1:0] STEPS  = STEP_W'(W);

    logic [W-1:0]      r_bin;
    logic [7:0]        r_shift;
    logic [7:0]        w_adj;
    logic [7:0]        w_shift_next;
    logic [STEP_W-1:0] r_steps;
    logic              r_busy;
    logic [3:0]        r_bcd_tens;
    logic [3:0]        r_bcd_ones;
    logic              r_bcd_valid;

    // Add-3 correction on each BCD digit before it is shifted
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit_adj
            assign w_adj[gi*4 +: 4] = (r_shift[gi*4 +: 4] >= 4'd5) ?
                                      (r_shift[gi*4 +: 4] + 4'd3) : r_shift[gi*4 +: 4];
        end
    endgenerate

    assign w_shift_next = {w_adj[6:0], r_bin[W-1]};

    // Converter: loads on the edge the count changes (reset counts as a load of zero),
    // then shifts one binary bit per cycle; digits update only when all W bits are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin       <= '0;
            r_shift     <= '0;
            r_steps     <= STEPS;
            r_busy      <= 1'b1;
            r_bcd_tens  <= 4'd0;
            r_bcd_ones  <= 4'd0;
            r_bcd_valid <= 1'b0;
        end else if (w_chg_next) begin
            r_bin       <= w_count_next;
            r_shift     <= '0;
            r_steps     <= STEPS;
            r_busy      <= 1'b1;
            r_bcd_valid <= 1'b0;
        end else if (r_busy) begin
            r_bin   <= r_bin << 1;
            r_shift <= w_shift_next;
            r_steps <= r_steps - STEP_W'(1);
            if (r_steps == STEP_W'(1)) begin
                r_busy      <= 1'b0;
                r_bcd_tens  <= w_shift_next[7:4];
                r_bcd_ones  <= w_shift_next[3:0];
                r_bcd_valid <= 1'b1;
            end
        end
    end

    assign bcd_tens  = r_bcd_tens;
    assign bcd_ones  = r_bcd_ones;
    assign bcd_valid = r_bcd_valid;
`else
    assign bcd_tens  = 4'd0;
    assign bcd_ones  = 4'd0;
    assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Self-checking bench for parking_occupancy_counter. Stimulus pushes the expected
// post-edge response into a queue; an independent monitor pops one entry per clock
// edge and compares it with the registered outputs.
// Default build exercises MAX_CAP=3, W=2; with OCC_BCD_EN it exercises MAX_CAP=99, W=7.
module tb_parking_occupancy_counter;

`ifdef OCC_BCD_EN
    localparam int MAX_CAP = 99;
    localparam int W       = 7;
`else
    localparam int MAX_CAP = 3;
    localparam int W       = 2;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enter = 1'b0;
    logic         exit = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] count;
    logic         empty;
    logic         full;
    logic         count_chg;
    logic         overflow_err;
    logic         underflow_err;
    logic [3:0]   bcd_tens;
    logic [3:0]   bcd_ones;
    logic         bcd_valid;

    typedef struct {
        string        name;
        logic [W-1:0] count;
        logic [4:0]   flags;   // {empty, full, count_chg, overflow_err, underflow_err}
        logic [8:0]   bcd;     // {tens, ones, valid}
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    parking_occupancy_counter #(
        .MAX_CAP(MAX_CAP),
        .W      (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enter        (enter),
        .exit         (exit),
        .err_clr      (err_clr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .count_chg    (count_chg),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .bcd_valid    (bcd_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs {reset, enter, exit, err_clr} and queue the expected result
    task automatic step(input string nm, input logic [3:0] in_v, input int cnt,
                        input logic [4:0] fl, input logic [8:0] bcd);
        exp_t e;
        @(negedge clk);
        {reset, enter, exit, err_clr} = in_v;
        e.name  = nm;
        e.count = cnt[W-1:0];
        e.flags = fl;
        e.bcd   = bcd;
        q.push_back(e);
    endtask

    // Monitor: one queued expectation per edge, sampled 1 time unit after the edge
    initial begin
        exp_t       e;
        logic [4:0] got_fl;
        logic [8:0] got_bcd;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e       = q.pop_front();
                got_fl  = {empty, full, count_chg, overflow_err, underflow_err};
                got_bcd = {bcd_tens, bcd_ones, bcd_valid};
                n_checks++;
                if (count !== e.count || got_fl !== e.flags || got_bcd !== e.bcd) begin
                    n_fail++;
                    $display("FAIL %s: got count=%0d flags(e,f,chg,ovf,unf)=%b bcd=%h/%h/%b, expected count=%0d flags=%b bcd=%h/%h/%b",
                             e.name, count, got_fl, bcd_tens, bcd_ones, bcd_valid,
                             e.count, e.flags, e.bcd[8:5], e.bcd[4:1], e.bcd[0]);
                end else begin
                    $display("ok   %s: count=%0d flags=%b bcd=%h/%h/%b",
                             e.name, count, got_fl, bcd_tens, bcd_ones, bcd_valid);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
`ifdef OCC_BCD_EN
        step("reset", 4'b1000, 0, 5'b10000, {4'd0, 4'd0, 1'b0});
        for (int i = 1; i <= 47; i++)
            step($sformatf("enter_to_%0d", i), 4'b0100, i, 5'b00100, {4'd0, 4'd0, 1'b0});
        for (int i = 0; i < 3; i++)
            step("conv47_busy", 4'b0000, 47, 5'b00000, {4'd0, 4'd0, 1'b0});
        step("enter_restart_48", 4'b0100, 48, 5'b00100, {4'd0, 4'd0, 1'b0});
        for (int i = 0; i < 6; i++)
            step("conv48_busy", 4'b0000, 48, 5'b00000, {4'd0, 4'd0, 1'b0});
        step("conv48_done", 4'b0000, 48, 5'b00000, {4'd4, 4'd8, 1'b1});
        step("exit_to_47", 4'b0010, 47, 5'b00100, {4'd4, 4'd8, 1'b0});
        for (int i = 0; i < 6; i++)
            step("conv47_hold", 4'b0000, 47, 5'b00000, {4'd4, 4'd8, 1'b0});
        step("conv47_done", 4'b0000, 47, 5'b00000, {4'd4, 4'd7, 1'b1});
        step("reset_mid", 4'b1000, 0, 5'b10000, {4'd0, 4'd0, 1'b0});
        for (int i = 0; i < 6; i++)
            step("conv0_busy", 4'b0000, 0, 5'b10000, {4'd0, 4'd0, 1'b0});
        step("conv0_done", 4'b0000, 0, 5'b10000, {4'd0, 4'd0, 1'b1});
`else
        step("reset",        4'b1000, 0, 5'b10000, 9'd0);
        step("idle_empty",   4'b0000, 0, 5'b10000, 9'd0);
        step("enter_1",      4'b0100, 1, 5'b00100, 9'd0);
        step("enter_2",      4'b0100, 2, 5'b00100, 9'd0);
        step("enter_3_full", 4'b0100, 3, 5'b01100, 9'd0);
        step("hold_full",    4'b0000, 3, 5'b01000, 9'd0);
        step("overflow",     4'b0100, 3, 5'b01010, 9'd0);
        step("ovf_sticky",   4'b0000, 3, 5'b01010, 9'd0);
        step("ovf_clear",    4'b0001, 3, 5'b01000, 9'd0);
        step("ovf_set_wins", 4'b0101, 3, 5'b01010, 9'd0);
        step("ovf_clear2",   4'b0001, 3, 5'b01000, 9'd0);
        step("exit_from_3",  4'b0010, 2, 5'b00100, 9'd0);
        step("enter_exit_2", 4'b0110, 2, 5'b00000, 9'd0);
        step("exit_to_1",    4'b0010, 1, 5'b00100, 9'd0);
        step("exit_to_0",    4'b0010, 0, 5'b10100, 9'd0);
        step("underflow",    4'b0010, 0, 5'b10001, 9'd0);
        step("unf_set_wins", 4'b0011, 0, 5'b10001, 9'd0);
        step("unf_clear",    4'b0001, 0, 5'b10000, 9'd0);
        step("enter_exit_0", 4'b0110, 0, 5'b10000, 9'd0);
        step("underflow2",   4'b0010, 0, 5'b10001, 9'd0);
        step("enter_keep_e", 4'b0100, 1, 5'b00101, 9'd0);
        step("enter_keep_e2",4'b0100, 2, 5'b00101, 9'd0);
        step("reset_mid",    4'b1100, 0, 5'b10000, 9'd0);
        step("enter_post_rst",4'b0100, 1, 5'b00100, 9'd0);
        step("exit_post_rst",4'b0010, 0, 5'b10100, 9'd0);
`endif
        @(negedge clk);
        {reset, enter, exit, err_clr} = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
